// File: rtl/serial_loop_memory_pkg.sv
// Shared constants for the serial loop memory tile: default geometry used by
// the tile top, the memory and its bench.
package serial_loop_memory_pkg;
    localparam int SLM_WORD_WIDTH = 8;
    localparam int SLM_WORD_COUNT = 64;
endpackage

// File: rtl/serial_loop_memory_if.sv
// Serial load/read bus of the loop memory: control bits in, word strobe out.
interface serial_loop_memory_if
    import serial_loop_memory_pkg::*;
#(
    parameter int WORD_WIDTH = SLM_WORD_WIDTH,
    parameter int WORD_COUNT = SLM_WORD_COUNT
) ();
    localparam int IDX_W = $clog2(WORD_COUNT);

    logic                  hold;
    logic                  clear;
    logic                  write;
    logic                  din;
    logic [WORD_WIDTH-1:0] out;
    logic                  word_valid;
    logic [IDX_W-1:0]      word_index;
    logic                  frame_start;

    modport master (
        output hold, clear, write, din,
        input  out, word_valid, word_index, frame_start
    );
    modport slave (
        input  hold, clear, write, din,
        output out, word_valid, word_index, frame_start
    );
endinterface

// File: rtl/serial_frame_counter.sv
// Bit/word position tracker for the loop memory: wraps per word and per frame
// and produces the registered word strobe, index and frame-start pulse.
module serial_frame_counter
    import serial_loop_memory_pkg::*;
#(
    parameter int WORD_WIDTH = SLM_WORD_WIDTH,
    parameter int WORD_COUNT = SLM_WORD_COUNT,
    localparam int IDX_W     = $clog2(WORD_COUNT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    output logic             word_end_o,
    output logic             word_valid_o,
    output logic [IDX_W-1:0] word_index_o,
    output logic             frame_start_o
);
    localparam int BIT_W = $clog2(WORD_WIDTH);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(WORD_WIDTH - 1);
    localparam logic [IDX_W-1:0] WORD_LAST = IDX_W'(WORD_COUNT - 1);

    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [IDX_W-1:0] word_cnt_q, word_cnt_d;
    logic [IDX_W-1:0] word_index_q, word_index_d;
    logic             valid_q, valid_d;
    logic             fs_q, fs_d;

    assign word_end_o = en_i && (bit_cnt_q == BIT_LAST);

    always_comb begin
        bit_cnt_d    = bit_cnt_q;
        word_cnt_d   = word_cnt_q;
        word_index_d = word_index_q;
        valid_d      = 1'b0;
        fs_d         = 1'b0;
        if (en_i) begin
            bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + BIT_W'(1);
            if (word_end_o) begin
                // explicit compare keeps non-power-of-two frames wrapping correctly
                word_cnt_d   = (word_cnt_q == WORD_LAST) ? '0 : word_cnt_q + IDX_W'(1);
                word_index_d = word_cnt_q;
                valid_d      = 1'b1;
                fs_d         = (word_cnt_q == '0);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt_q    <= '0;
            word_cnt_q   <= '0;
            word_index_q <= '0;
            valid_q      <= 1'b0;
            fs_q         <= 1'b0;
        end else begin
            bit_cnt_q    <= bit_cnt_d;
            word_cnt_q   <= word_cnt_d;
            word_index_q <= word_index_d;
            valid_q      <= valid_d;
            fs_q         <= fs_d;
        end
    end

    assign word_valid_o  = valid_q;
    assign word_index_o  = word_index_q;
    assign frame_start_o = fs_q;
endmodule

// File: rtl/serial_loop_memory.sv
// WORD_COUNT x WORD_WIDTH recirculating shift-register store, one bit per
// clock, with hold, zero-fill and a per-word capture strobe.
module serial_loop_memory
    import serial_loop_memory_pkg::*;
#(
    parameter int WORD_WIDTH = SLM_WORD_WIDTH,
    parameter int WORD_COUNT = SLM_WORD_COUNT
) (
    input logic                   clk,
    input logic                   reset,
    serial_loop_memory_if.slave   bus
);
    localparam int L = WORD_WIDTH * WORD_COUNT;

    logic [L-1:0]          loop_q;
    logic [WORD_WIDTH-1:0] out_q;
    logic                  shift;
    logic                  nb;
    logic                  word_end;

    assign shift = !bus.hold;

    always_comb begin
        nb = loop_q[L-1];
        if (bus.clear)      nb = 1'b0;
        else if (bus.write) nb = bus.din;
    end

    // No reset on the loop: contents survive reset and stay frozen while it is held.
    always_ff @(posedge clk) begin
        if (reset && shift) loop_q <= {loop_q[L-2:0], nb};
    end

    // Captured word includes the bit entering on this edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        out_q <= '0;
        else if (word_end) out_q <= {loop_q[WORD_WIDTH-2:0], nb};
    end

    serial_frame_counter #(
        .WORD_WIDTH (WORD_WIDTH),
        .WORD_COUNT (WORD_COUNT)
    ) u_cnt (
        .clk           (clk),
        .reset         (reset),
        .en_i          (shift),
        .word_end_o    (word_end),
        .word_valid_o  (bus.word_valid),
        .word_index_o  (bus.word_index),
        .frame_start_o (bus.frame_start)
    );

    assign bus.out = out_q;
endmodule

// File: tb/tb_serial_loop_memory.sv
// Scoreboard bench: two loops (4 words and 3 words of 8 bits) share one random
// stimulus stream; a bit-queue model predicts every word strobe.
module tb_serial_loop_memory;
    localparam int W = 8;
    localparam int CNT [2] = '{4, 3};

    typedef struct {
        logic [7:0] v;
        int         idx;
        bit         fs;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic hold = 1'b0, clear = 1'b0, write = 1'b1, din = 1'b0;

    int total = 0;
    int bad   = 0;

    serial_loop_memory_if #(.WORD_WIDTH(W), .WORD_COUNT(4)) ifa ();
    serial_loop_memory_if #(.WORD_WIDTH(W), .WORD_COUNT(3)) ifb ();

    assign ifa.hold = hold;  assign ifa.clear = clear;
    assign ifa.write = write; assign ifa.din = din;
    assign ifb.hold = hold;  assign ifb.clear = clear;
    assign ifb.write = write; assign ifb.din = din;

    serial_loop_memory #(.WORD_WIDTH(W), .WORD_COUNT(4)) u_a (
        .clk(clk), .reset(rst_n), .bus(ifa.slave));
    serial_loop_memory #(.WORD_WIDTH(W), .WORD_COUNT(3)) u_b (
        .clk(clk), .reset(rst_n), .bus(ifb.slave));

    logic       vld [2];
    logic [7:0] ov  [2];
    logic [1:0] iv  [2];
    logic       fv  [2];
    assign vld[0] = ifa.word_valid; assign ov[0] = ifa.out;
    assign iv[0]  = ifa.word_index; assign fv[0] = ifa.frame_start;
    assign vld[1] = ifb.word_valid; assign ov[1] = ifb.out;
    assign iv[1]  = ifb.word_index; assign fv[1] = ifb.frame_start;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: the loop is a bit queue (front = oldest bit); a word is the
    // last W bits pushed, every W-th accepted edge since reset release.
    bit   mq  [2][$];
    int   sc  [2] = '{0, 0};
    exp_t sbq [2][$];

    always @(negedge rst_n) begin
        sc[0] = 0;
        sc[1] = 0;
    end

    always @(posedge clk) begin
        if (rst_n && !hold) begin
            for (int d = 0; d < 2; d++) begin
                bit   nb;
                exp_t e;
                nb = clear ? 1'b0 : (write ? din : mq[d][0]);
                if (mq[d].size() == W * CNT[d]) void'(mq[d].pop_front());
                mq[d].push_back(nb);
                sc[d]++;
                if (sc[d] % W == 0) begin
                    for (int b = 0; b < W; b++) e.v[W-1-b] = mq[d][mq[d].size() - W + b];
                    e.idx = (sc[d] / W - 1) % CNT[d];
                    e.fs  = (e.idx == 0);
                    sbq[d].push_back(e);
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        for (int d = 0; d < 2; d++) begin
            if (vld[d]) begin
                if (sbq[d].size() == 0) begin
                    chk($sformatf("unexpected_strobe%0d", d), 1, 0);
                end else begin
                    exp_t e;
                    e = sbq[d].pop_front();
                    chk($sformatf("out%0d", d), int'(ov[d]), int'(e.v));
                    chk($sformatf("index%0d", d), int'(iv[d]), e.idx);
                    chk($sformatf("frame_start%0d", d), int'(fv[d]), int'(e.fs));
                end
            end else if (fv[d]) begin
                chk($sformatf("frame_start_no_valid%0d", d), 1, 0);
            end
        end
    end

    task automatic step(input bit h, input bit c, input bit w, input bit d);
        hold = h; clear = c; write = w; din = d;
        @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_out%0d", tag, d), int'(ov[d]), 0);
            chk($sformatf("%s_valid%0d", tag, d), int'(vld[d]), 0);
            chk($sformatf("%s_index%0d", tag, d), int'(iv[d]), 0);
            chk($sformatf("%s_fs%0d", tag, d), int'(fv[d]), 0);
        end
    endtask

    // Reset between edges; outputs must clear without a clock edge.
    task automatic do_reset(input string tag);
        #2 rst_n = 1'b0;
        #1 check_zero({tag, "_async"});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            hold = 1'(i); write = 1'(~i); din = 1'($urandom);
            check_zero({tag, "_held"});
        end
        rst_n = 1'b1;
    endtask

    logic [7:0] words [4] = '{8'h12, 8'h34, 8'h56, 8'h78};

    initial begin
        logic [7:0] wv;
        repeat (3) @(negedge clk);
        check_zero("por");
        rst_n = 1'b1;

        // load the loop MSB-first
        for (int k = 0; k < 4; k++) begin
            wv = words[k];
            for (int b = W - 1; b >= 0; b--) step(0, 0, 1, wv[b]);
        end
        // one full recirculation
        repeat (32) step(0, 0, 0, 0);
        // freeze in the middle of word 2
        repeat (19) step(0, 0, 0, 0);
        repeat (5)  step(1, 0, 0, 1);
        repeat (13) step(0, 0, 0, 0);
        // zero-fill word 1 while write/din are high, then read back a full loop
        repeat (8)  step(0, 0, 0, 0);
        repeat (8)  step(0, 1, 1, 1);
        repeat (16) step(0, 0, 0, 0);
        repeat (32) step(0, 0, 0, 0);
        // mid-word reset: counters restart, loop contents keep their place
        repeat (3)  step(0, 0, 0, 0);
        do_reset("rst_mid");
        repeat (40) step(0, 0, 0, 0);

        for (int i = 0; i < 300; i++) begin
            if (i == 150) do_reset("rst_rand");
            step(($urandom % 5) == 0, ($urandom % 10) == 0,
                 ($urandom % 3) == 0, 1'($urandom));
        end
        repeat (3) step(1, 0, 0, 0);
        chk("drain0", sbq[0].size(), 0);
        chk("drain1", sbq[1].size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
